// File: rtl/fifo_access_ctrl.sv
// fifo_access_ctrl: front-end sequencer for an 8-bit FIFO.
// Write side: round-robin arbitration of NREQ producers onto the FIFO write port, with
// only the HI_PRI requesters eligible while the FIFO reports its threshold.
// Read side: prefetches FIFO words into a 2-entry output buffer behind valid/ready.
// Overflow/underflow events from the FIFO are latched as sticky error flags.
module fifo_access_ctrl #(
    parameter int unsigned          NREQ   = 4,
    parameter int unsigned          DW     = 8,
    parameter logic [NREQ-1:0]      HI_PRI = {{(NREQ-1){1'b0}}, 1'b1}
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    // Producers
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*DW-1:0]      i_req_data,
    output logic [NREQ-1:0]         o_req_ready,
    // FIFO ports
    output logic                    o_fifo_wr,
    output logic [DW-1:0]           o_fifo_din,
    output logic                    o_fifo_rd,
    input  logic [DW-1:0]           i_fifo_dout,
    input  logic                    i_fifo_full,
    input  logic                    i_fifo_empty,
    input  logic                    i_fifo_threshold,
    input  logic                    i_fifo_overflow,
    input  logic                    i_fifo_underflow,
    // Consumer
    output logic                    o_out_valid,
    output logic [DW-1:0]           o_out_data,
    input  logic                    i_out_ready,
    // Status
    output logic [2:0]              o_grant_id,
    output logic                    o_err_ovf,
    output logic                    o_err_udf
);

    // Pointer resets to the last index so that requester 0 is first in line.
    localparam logic [2:0] PTR_RST = 3'(NREQ - 1);

    logic [2:0]         r_rr_ptr;
    logic [2:0]         r_grant_id;
    logic [NREQ-1:0]    w_elig;
    logic [7:0]         w_elig_ext;
    logic               w_gnt_any;
    logic [2:0]         w_gnt_idx;
    logic [2:0]         w_scan_idx;
    logic [NREQ-1:0]    w_gnt_oh;
    logic [DW-1:0]      w_gnt_data;

    logic [1:0]         r_occ;
    logic               r_inflight;
    logic [DW-1:0]      r_head;
    logic [DW-1:0]      r_tail;
    logic               w_pop;
    logic [2:0]         w_need;
    logic               w_rd;

    logic               r_err_ovf;
    logic               r_err_udf;

    // Eligibility and round-robin scan starting just after the last granted index.
    always_comb begin
        w_elig     = i_fifo_full ? '0
                   : (i_req_valid & (i_fifo_threshold ? HI_PRI : {NREQ{1'b1}}));
        w_elig_ext = 8'(w_elig);
        w_gnt_any  = 1'b0;
        w_gnt_idx  = r_rr_ptr;
        w_scan_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_scan_idx = 3'((32'(r_rr_ptr) + k) % NREQ);
            if (!w_gnt_any && w_elig_ext[w_scan_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan_idx;
            end
        end
    end

    // One-hot grant and write-data mux.
    always_comb begin
        w_gnt_oh   = '0;
        w_gnt_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (w_gnt_any && (w_gnt_idx == 3'(j))) begin
                w_gnt_oh[j] = 1'b1;
                w_gnt_data  = i_req_data[j*DW +: DW];
            end
        end
    end

    // Read request: keep buffer plus in-flight word within two entries.
    always_comb begin
        w_pop  = o_out_valid & i_out_ready;
        w_need = 3'(r_occ) + 3'(r_inflight) - 3'(w_pop);
        w_rd   = !i_fifo_empty && (w_need < 3'd2);
    end

    // Strobes are held low for the whole time reset is asserted.
    assign o_req_ready = i_rst_n ? w_gnt_oh : '0;
    assign o_fifo_wr   = i_rst_n & w_gnt_any;
    assign o_fifo_din  = w_gnt_data;
    assign o_fifo_rd   = i_rst_n & w_rd;
    assign o_out_valid = (r_occ != 2'd0);
    assign o_out_data  = r_head;
    assign o_grant_id  = r_grant_id;
    assign o_err_ovf   = r_err_ovf;
    assign o_err_udf   = r_err_udf;

    // Round-robin pointer and last-grant index advance only on a grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr   <= PTR_RST;
            r_grant_id <= 3'd0;
        end else if (w_gnt_any) begin
            r_rr_ptr   <= w_gnt_idx;
            r_grant_id <= w_gnt_idx;
        end
    end

    // Output buffer: head feeds the consumer, tail holds the second word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_inflight <= w_rd;
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_head <= i_fifo_dout;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_head <= i_fifo_dout;
                    end else if (r_inflight) begin
                        r_tail <= i_fifo_dout;
                        r_occ  <= 2'd2;
                    end else if (w_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    // Full buffer never has a word in flight without a pop alongside it.
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (r_inflight) begin
                            r_tail <= i_fifo_dout;
                        end else begin
                            r_occ  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | i_fifo_overflow;
            r_err_udf <= r_err_udf | i_fifo_underflow;
        end
    end

endmodule
